// File: rtl/req_arbiter4.sv
// Four-requester arbiter with fixed or round-robin priority and an optional hold timeout.
// Grant outputs are registered. A release or preempt hands over with no idle cycle in between.
module req_arbiter4 #(
  parameter bit          RR       = 1'b1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] hold_max = 8'(MAX_HOLD);
  localparam bit         hold_en  = (MAX_HOLD != 0);

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] id_d;
  logic [3:0] gnt_d;

  logic [1:0] owner;
  logic [1:0] ptr_rel;
  logic [3:0] others;
  logic [2:0] pick_idle, pick_oth;

  // Returns {found, index}. The search starts at top and descends with wrap, so the
  // last hit written, at k = 0, is the highest-priority hit.
  function automatic logic [2:0] select(input logic [3:0] mask, input logic [1:0] top);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = top - 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    owner     = gnt_id;
    others    = req & ~(4'b0001 << owner);
    ptr_rel   = RR ? owner - 2'd1 : 2'd3;
    pick_idle = select(req, RR ? ptr_q : 2'd3);
    // On release req[owner] is already 0, so others equals req.
    pick_oth  = select(others, ptr_rel);

    state_d = state_q;
    id_d    = gnt_id;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          id_d    = pick_idle[1:0];
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          ptr_d = ptr_rel;
          if (pick_oth[2]) begin
            id_d   = pick_oth[1:0];
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            id_d    = 2'd0;
            hold_d  = 8'd0;
          end
        end else if (hold_en && hold_q >= hold_max) begin
          if (pick_oth[2]) begin
            ptr_d  = ptr_rel;
            id_d   = pick_oth[1:0];
            hold_d = 8'd1;
          end else begin
            hold_d = hold_max;
          end
        end else if (hold_q != 8'hff) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase

    gnt_d = (state_d == GRANT) ? (4'b0001 << id_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_id    <= 2'd0;
      ptr_q     <= 2'd3;
      hold_q    <= 8'd0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id    <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= |gnt_d;
    end
  end

endmodule

// File: doc/req_arbiter4.md
# req_arbiter4

Four-requester arbiter that shares one downstream resource, such as a bus or datapath port, among requesters `req[3:0]`. Each arbitration picks the winner by priority encoding: fixed (index 3 highest) or rotating round-robin. The winner keeps the grant until it drops its request, or until a hold-timeout preempts it in favour of waiting requesters. Outputs are registered and feed the resource mux select and per-requester grant lines.

## Interface
- `RR`, default 1: 1 = round-robin rotating priority; 0 = fixed priority (3 > 2 > 1 > 0).
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before preemption, legal range 0–255. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  4  request lines, level-sensitive; bit i is requester i.
- `gnt`  out  4  one-hot grant, all-zero when idle.
- `gnt_id`  out  2  binary index of the current owner, 2'b00 when idle.
- `gnt_valid`  out  1  high when any grant is active (equals |gnt).

## Operation
- State machine has two states:
  - IDLE: no owner.
  - GRANT: owner held in `gnt_id`.
- Registers: `state`, `gnt_id`, `ptr[1:0]` (highest-priority index in RR mode), `hold_cnt[7:0]`.
- Reset values:
  - state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0.
  - ptr=2'd3, so the first RR arbitration matches fixed priority.
  - hold_cnt=0.
- Winner selection, over a candidate mask:
  - RR=0: highest set index wins.
  - RR=1: search starts at ptr and descends with wrap (ptr, ptr-1, …, ptr-3 mod 4); first set bit wins.
- IDLE transitions:
  - If req≠0: winner = select(req); go to GRANT; hold_cnt=1.
  - Otherwise stay in IDLE.
- GRANT transitions, with owner o:
  - Release, when req[o]=0:
    - Set ptr = o-1 mod 4.
    - If req≠0: new winner = select(req), chosen with the updated ptr; hold_cnt=1; stay in GRANT.
    - Else: go to IDLE and clear outputs.
  - Preempt, when req[o]=1, MAX_HOLD≠0, hold_cnt≥MAX_HOLD and (req & ~(1<<o))≠0:
    - Set ptr = o-1 mod 4.
    - Winner = select(req & ~(1<<o)); hold_cnt=1.
    - In fixed mode, the preempted owner is still excluded from this one arbitration.
  - Timeout with no other requester: owner keeps the grant and hold_cnt saturates at MAX_HOLD.
  - Otherwise: hold_cnt increments, saturating at 255.
- ptr changes only on release or preempt, and only when RR=1. When RR=0, ptr stays at 3.
- `gnt` is always one-hot or zero. `gnt_id` and `gnt` always agree.

## Timing
- Request-to-grant latency is 1 cycle. A req first sampled high at edge n produces gnt valid after edge n.
- Handover takes zero idle cycles. When the owner's req is sampled low at edge n and another req is pending, the new gnt is valid after edge n. The old gnt is low in that same cycle, so grants never overlap.
- Release with no other request: gnt=0 after edge n.
- hold_cnt=k means the owner has held gnt for k cycles. With MAX_HOLD=M, preemption occurs at the edge ending the M-th grant cycle, so the owner sees exactly M grant cycles.
- A req pulse that rises and falls between edges is never seen.
- A requester that drops req while not granted loses nothing. No request is latched.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and ptr returns to 3. After deassertion, arbitration restarts as from power-up on the next edge.
- A req change in the same cycle as reset release is ignored until the first edge with rst=0.

## Test plan
- Reset: with rst=1 and req=4'b1111 → gnt=0000, gnt_id=00, gnt_valid=0. Release rst → next edge gnt=1000, gnt_id=11.
- Fixed priority (RR=0, MAX_HOLD=0), req=0111:
  - → gnt=0100 and held.
  - Drop req[2] → next edge gnt=0010.
  - Drop all → gnt=0000.
- Round-robin (RR=1, MAX_HOLD=0), req=1111 held; each owner drops its req for one cycle after 2 grant cycles → grant order 3,2,1,0,3 with no idle cycle between owners.
- Timeout (RR=1, MAX_HOLD=4):
  - req=1000 steady, then req[0] added → owner 3 gets exactly 4 grant cycles, then gnt=0001 with hold_cnt=1.
  - Lone requester 1000 with MAX_HOLD=4 → grant held indefinitely.
- Simultaneous release and new request: owner 2 drops req in the same cycle that req[3] rises (RR=1) → next edge gnt=0010 if req[1] is pending (ptr=1), else gnt=1000.
- Reset mid-operation: assert rst in the 3rd grant cycle of owner 1 → gnt=0000 before the next edge. Deassert with req=0011 → gnt=0010 (ptr back to 3).
